// File: rtl/magic_seq_pkg.sv
// Shared constants, instruction layout and FSM states for the MAGIC NOR sequencer.
// Instruction word is {op[1:0], a, b, d}, opcode in the MSBs.
package magic_seq_pkg;

  localparam int SEQ_ADDR_W     = 6;
  localparam int SEQ_PROG_DEPTH = 32;
  localparam int SEQ_PC_W       = 5;
  localparam int SEQ_INSTR_W    = 2 + 3 * SEQ_ADDR_W;

  localparam logic [1:0] OP_NOR2 = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  localparam logic PH_INIT = 1'b0;
  localparam logic PH_EVAL = 1'b1;

  localparam int FLD_D_LSB  = 0;
  localparam int FLD_B_LSB  = SEQ_ADDR_W;
  localparam int FLD_A_LSB  = 2 * SEQ_ADDR_W;
  localparam int FLD_OP_LSB = 3 * SEQ_ADDR_W;

  typedef struct packed {
    logic [1:0]            op;
    logic [SEQ_ADDR_W-1:0] a;
    logic [SEQ_ADDR_W-1:0] b;
    logic [SEQ_ADDR_W-1:0] d;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_INIT,
    S_EVAL,
    S_FIN
  } state_t;

endpackage

// File: rtl/magic_prog_mem.sv
// Microprogram RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (valid next cycle).
module magic_prog_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/magic_nor_sequencer.sv
// Steps a NOR/NOT microprogram onto a MAGIC crossbar, one INIT+EVAL pair per gate.
// Ports: host load (prog_*), start/busy/done/err/op_count, crossbar req/ack bundle (xb_*).
module magic_nor_sequencer
  import magic_seq_pkg::*;
#(
  parameter int ADDR_W     = SEQ_ADDR_W,
  parameter int PROG_DEPTH = SEQ_PROG_DEPTH,
  parameter int PC_W       = SEQ_PC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_waddr,
  input  logic [2+3*ADDR_W-1:0] prog_wdata,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [PC_W:0]         op_count,
  output logic                  xb_req,
  output logic                  xb_phase,
  output logic [ADDR_W-1:0]     xb_src_a,
  output logic [ADDR_W-1:0]     xb_src_b,
  output logic [ADDR_W-1:0]     xb_dst,
  input  logic                  xb_ack
);

  localparam int IW = 2 + 3 * ADDR_W;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);
  localparam logic [PC_W:0]   CNT_MAX = '1;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [PC_W:0]     cnt_n;
  logic              err_n;
  logic              mem_re;
  logic [IW-1:0]     rdata;

  logic [1:0]        op;
  logic [ADDR_W-1:0] fa, fb, fd;
  logic              hazard;
  logic              at_last;

  // Writes are locked out while a run owns the program.
  magic_prog_mem #(
    .DEPTH(PROG_DEPTH),
    .AW   (PC_W),
    .W    (IW)
  ) u_mem (
    .clk  (clk),
    .we   (prog_we && !busy),
    .waddr(prog_waddr),
    .wdata(prog_wdata),
    .re   (mem_re),
    .raddr(pc),
    .rdata(rdata)
  );

  // rdata only reloads in FETCH, so it holds the
  // current instruction stable through INIT/EVAL.
  assign op = rdata[3*ADDR_W +: 2];
  assign fa = rdata[2*ADDR_W +: ADDR_W];
  assign fb = rdata[ADDR_W +: ADDR_W];
  assign fd = rdata[0 +: ADDR_W];

  // Output cell may not also be a source.
  assign hazard = (op == OP_NOR2 && (fd == fa || fd == fb))
               || (op == OP_NOT && fd == fa);
  assign at_last = (pc == PC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      op_count <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      op_count <= cnt_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    cnt_n    = op_count;
    err_n    = err;
    busy     = 1'b0;
    done     = 1'b0;
    mem_re   = 1'b0;
    xb_req   = 1'b0;
    xb_phase = PH_INIT;
    xb_src_a = '0;
    xb_src_b = '0;
    xb_dst   = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_re  = 1'b1;
        state_n = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        unique case (1'b1)
          op == OP_END: state_n = S_FIN;
          op == OP_NOP: begin
            if (at_last) begin
              err_n   = 1'b1;
              state_n = S_FIN;
            end else begin
              pc_n    = pc + 1'b1;
              state_n = S_FETCH;
            end
          end
          hazard: begin
            err_n   = 1'b1;
            state_n = S_FIN;
          end
          default: state_n = S_INIT;
        endcase
      end
      S_INIT: begin
        busy   = 1'b1;
        xb_req = 1'b1;
        xb_dst = fd;
        if (xb_ack) state_n = S_EVAL;
      end
      S_EVAL: begin
        busy     = 1'b1;
        xb_req   = 1'b1;
        xb_phase = PH_EVAL;
        xb_src_a = fa;
        xb_src_b = (op == OP_NOT) ? fa : fb;
        xb_dst   = fd;
        if (xb_ack) begin
          if (op_count != CNT_MAX) cnt_n = op_count + 1'b1;
          if (at_last) begin
            err_n   = 1'b1;
            state_n = S_FIN;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Self-checking bench for magic_nor_sequencer: program-level trace model
// compared every cycle, plus literal checks on latency, err and op_count.
module tb_magic_nor_sequencer;
  import magic_seq_pkg::*;

  localparam int AW    = SEQ_ADDR_W;
  localparam int PW    = SEQ_PC_W;
  localparam int DEPTH = SEQ_PROG_DEPTH;
  localparam int IW    = SEQ_INSTR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_waddr = '0;
  logic [IW-1:0] prog_wdata = '0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [PW:0]   op_count;
  logic          xb_req, xb_phase;
  logic [AW-1:0] xb_src_a, xb_src_b, xb_dst;
  logic          xb_ack;

  logic ack_real = 1'b0;
  logic force_ack = 1'b0;
  assign xb_ack = ack_real | force_ack;

  magic_nor_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .op_count  (op_count),
    .xb_req    (xb_req),
    .xb_phase  (xb_phase),
    .xb_src_a  (xb_src_a),
    .xb_src_b  (xb_src_b),
    .xb_dst    (xb_dst),
    .xb_ack    (xb_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          req;
    logic          phase;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic [PW:0]   cnt;
  } obs_t;

  obs_t   exp_q[$];
  instr_t prog[DEPTH];
  int     checks = 0;
  int     errors = 0;
  bit     cmp_en = 1'b1;
  int     di = 0;
  int     de = 0;

  function automatic instr_t mk(input logic [1:0] op, input int a, input int b, input int d);
    instr_t i;
    i.op = op;
    i.a  = AW'(a);
    i.b  = AW'(b);
    i.d  = AW'(d);
    return i;
  endfunction

  function automatic obs_t rec(input logic bz, input logic dn, input logic er,
                               input logic rq, input logic ph, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [AW-1:0] d, input int c);
    obs_t o;
    o.busy = bz; o.done = dn; o.err = er; o.req = rq; o.phase = ph;
    o.a = a; o.b = b; o.d = d; o.cnt = (PW+1)'(c);
    return o;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Expected cycle trace of one run, derived from the program and ack delays.
  task automatic build();
    int pc;
    int cnt;
    bit e;
    bit fin;
    instr_t w;
    pc = 0; cnt = 0; e = 1'b0; fin = 1'b0;
    while (!fin) begin
      w = prog[pc];
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, cnt));
      exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, cnt));
      if (w.op == OP_END) begin
        fin = 1'b1;
      end else if (w.op != OP_NOP) begin
        if (w.d == w.a || (w.op == OP_NOR2 && w.d == w.b)) begin
          e = 1'b1;
          fin = 1'b1;
        end else begin
          repeat (di + 1) exp_q.push_back(rec(1, 0, 0, 1, 0, 0, 0, w.d, cnt));
          repeat (de + 1)
            exp_q.push_back(rec(1, 0, 0, 1, 1, w.a,
                                (w.op == OP_NOT) ? w.a : w.b, w.d, cnt));
          cnt++;
        end
      end
      if (!fin) begin
        if (pc == DEPTH - 1) begin
          e = 1'b1;
          fin = 1'b1;
        end else begin
          pc++;
        end
      end
    end
    exp_q.push_back(rec(0, 1, e, 0, 0, 0, 0, 0, cnt));
    exp_q.push_back(rec(0, 0, e, 0, 0, 0, 0, 0, cnt));
  endtask

  always @(posedge clk) begin
    obs_t e;
    obs_t g;
    #1;
    if (cmp_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {busy, done, err, xb_req, xb_phase, xb_src_a, xb_src_b, xb_dst, op_count};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL trace t=%0t got %h want %h", $time, g, e);
      end
    end
  end

  // Crossbar model: acks after di/de wait cycles of each phase.
  logic prev_req = 1'b0;
  logic prev_ph = 1'b0;
  int   wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (xb_req && (!prev_req || xb_phase != prev_ph)) wcnt = 0;
    else if (xb_req) wcnt++;
    prev_req = xb_req;
    prev_ph  = xb_phase;
    ack_real = xb_req && (wcnt >= (xb_phase ? de : di));
  end

  task automatic load(input int addr, input instr_t w);
    @(negedge clk);
    prog_we = 1'b1;
    prog_waddr = PW'(addr);
    prog_wdata = w;
    @(negedge clk);
    prog_we = 1'b0;
    prog[addr] = w;
  endtask

  task automatic run(input bit mid_start, input bit stray, input bit wr_start,
                     input int waddr, input instr_t wdata, output int lat);
    int n;
    @(negedge clk);
    if (wr_start) begin
      prog_we = 1'b1;
      prog_waddr = PW'(waddr);
      prog_wdata = wdata;
      prog[waddr] = wdata;
    end
    start = 1'b1;
    if (stray) force_ack = 1'b1;
    build();
    n = 0;
    lat = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
      if (n == 1) begin
        start = 1'b0;
        prog_we = 1'b0;
      end
      if (n == 2) force_ack = 1'b0;
      if (mid_start && n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      if (done && lat == 0) lat = n;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    int n;
    instr_t nul;
    nul = mk(OP_END, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", xb_req, 0);
    chk("rst_done", done, 0);
    chk("rst_dst", xb_dst, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    load(0, mk(OP_NOR2, 1, 2, 5));
    load(1, mk(OP_END, 0, 0, 0));
    run(0, 0, 0, 0, nul, lat);
    chk("nor_lat", lat, 7);
    chk("nor_cnt", op_count, 1);
    chk("nor_err", err, 0);

    run(0, 0, 1, 0, mk(OP_NOT, 3, 9, 7), lat);
    chk("not_cnt", op_count, 1);
    chk("not_err", err, 0);

    di = 4;
    load(0, mk(OP_NOR2, 10, 11, 12));
    run(0, 1, 0, 0, nul, lat);
    chk("slow_lat", lat, 11);
    chk("slow_cnt", op_count, 1);
    di = 0;

    load(0, mk(OP_NOR2, 4, 6, 6));
    run(0, 0, 0, 0, nul, lat);
    chk("haz_lat", lat, 3);
    chk("haz_err", err, 1);
    chk("haz_cnt", op_count, 0);

    load(0, mk(OP_NOT, 5, 0, 5));
    run(0, 0, 0, 0, nul, lat);
    chk("haz_not_err", err, 1);

    load(0, mk(OP_NOR2, 1, 2, 5));
    run(0, 0, 0, 0, nul, lat);
    chk("clr_err", err, 0);
    chk("clr_cnt", op_count, 1);

    for (int i = 0; i < DEPTH; i++) load(i, mk(OP_NOP, 0, 0, 0));
    run(1, 0, 0, 0, nul, lat);
    chk("nop_lat", lat, 65);
    chk("nop_err", err, 1);
    chk("nop_cnt", op_count, 0);

    load(0, mk(OP_NOR2, 20, 21, 22));
    load(1, mk(OP_NOR2, 23, 24, 25));
    load(2, mk(OP_END, 0, 0, 0));
    cmp_en = 1'b0;
    de = 20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(xb_req && xb_phase && op_count == 1) && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        prog_we = 1'b1;
        prog_waddr = 2;
        prog_wdata = mk(OP_NOT, 4, 0, 4);
      end else begin
        prog_we = 1'b0;
      end
    end
    chk("eval2_reached", int'(n < 100), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_req", xb_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    prog_we = 1'b0;
    de = 0;
    @(negedge clk);
    cmp_en = 1'b1;
    run(0, 0, 0, 0, nul, lat);
    chk("rerun_cnt", op_count, 2);
    chk("rerun_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
